sbox_share_arb: RTL and testbench

//  Shares one bank of LANES S-box lanes between two requesters: the round datapath (D) and the
//  key schedule SubWord (K). Each lane is GF(2^8) inversion plus an affine map.

---
 rtl/sbox_share_arb.sv | 166 ++++++++++++++++
 tb/tb_sbox_share_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_arb.sv
// Shared AES S-box lane bank arbitrated round-robin between round datapath (D) and key schedule (K).
// Latency 1 (2 when SBOX_PIPE_REG_EN is defined), one word per cycle; EN=0 freezes every stage.
// Input side valid/ready (loser waits at most one cycle); output has no back-pressure.
module sbox_share_arb #(
    parameter int LANES = 4
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               EN,
    input  logic               d_vld,
    input  logic               d_dec,
    input  logic [8*LANES-1:0] d_din,
    output logic               d_rdy,
    input  logic               k_vld,
    input  logic [8*LANES-1:0] k_din,
    output logic               k_rdy,
    output logic [8*LANES-1:0] dout,
    output logic               dout_vld,
    output logic               dout_id,
    output logic               busy
);

    localparam int W = 8 * LANES;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 without a special case).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] fwd_aff(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Lane-wise transforms; bytes never interact.
    function automatic logic [W-1:0] pre_word(input logic [W-1:0] w, input logic dec);
        logic [W-1:0] r;
        r = w;
        for (int l = 0; l < LANES; l++) begin
            if (dec) r[8*l +: 8] = inv_aff(w[8*l +: 8]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] inv_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            r[8*l +: 8] = gf_inv(w[8*l +: 8]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] post_word(input logic [W-1:0] w, input logic dec);
        logic [W-1:0] r;
        r = w;
        for (int l = 0; l < LANES; l++) begin
            if (!dec) r[8*l +: 8] = fwd_aff(w[8*l +: 8]);
        end
        return r;
    endfunction

    // last_gnt: 1 = K won last, so D wins the next tie.
    logic           last_gnt;
    logic           gnt_d;
    logic           gnt_k;
    logic           acc;
    logic [W-1:0]   sel_word;
    logic           sel_dec;
    logic           sel_id;
    logic [W-1:0]   inv_out;

    assign gnt_d    = d_vld & (~k_vld | last_gnt);
    assign gnt_k    = k_vld & (~d_vld | ~last_gnt);
    assign d_rdy    = EN & gnt_d;
    assign k_rdy    = EN & gnt_k;
    assign acc      = d_rdy | k_rdy;
    assign sel_word = d_rdy ? d_din : k_din;
    assign sel_dec  = d_rdy & d_dec;
    assign sel_id   = k_rdy;
    assign inv_out  = inv_word(pre_word(sel_word, sel_dec));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last_gnt <= 1'b1;
        end else if (acc) begin
            last_gnt <= k_rdy;
        end
    end

`ifdef SBOX_PIPE_REG_EN
    logic           s1_vld;
    logic [W-1:0]   s1_inv;
    logic           s1_id;
    logic           s1_dec;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_vld   <= 1'b0;
            s1_inv   <= '0;
            s1_id    <= 1'b0;
            s1_dec   <= 1'b0;
            dout_vld <= 1'b0;
            dout     <= '0;
            dout_id  <= 1'b0;
        end else if (EN) begin
            s1_vld   <= acc;
            dout_vld <= s1_vld;
            if (acc) begin
                s1_inv <= inv_out;
                s1_id  <= sel_id;
                s1_dec <= sel_dec;
            end
            if (s1_vld) begin
                dout    <= post_word(s1_inv, s1_dec);
                dout_id <= s1_id;
            end
        end
    end

    assign busy = s1_vld | dout_vld;
`else
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dout_vld <= 1'b0;
            dout     <= '0;
            dout_id  <= 1'b0;
        end else if (EN) begin
            dout_vld <= acc;
            if (acc) begin
                dout    <= post_word(inv_out, sel_dec);
                dout_id <= sel_id;
            end
        end
    end

    assign busy = dout_vld;
`endif

endmodule

// File: tb/tb_sbox_share_arb.sv
// Bench for sbox_share_arb: directed cases, exhaustive round trip and random traffic against a
// table-driven reference model. Define SBOX_PIPE_REG_EN here too for the two-stage build.
module tb_sbox_share_arb;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        EN;
    logic        d_vld, d_dec, k_vld;
    logic [31:0] d_din, k_din;
    logic        d_rdy, k_rdy;
    logic [31:0] dout;
    logic        dout_vld, dout_id, busy;

    sbox_share_arb #(.LANES(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN),
        .d_vld(d_vld), .d_dec(d_dec), .d_din(d_din), .d_rdy(d_rdy),
        .k_vld(k_vld), .k_din(k_din), .k_rdy(k_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_id(dout_id), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference S-box tables built from the field definition.
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int acc, x;
        acc = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11B;
        end
        return acc[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] c, bi, s;
        c = 8'h63;
        for (int b = 0; b < 256; b++) begin
            bi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(b[7:0], y[7:0]) == 8'h01) bi = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = bi[i] ^ bi[(i+4)%8] ^ bi[(i+5)%8] ^ bi[(i+6)%8] ^ bi[(i+7)%8] ^ c[i];
            sb[b] = s;
            isb[s] = b[7:0];
        end
    endtask

    function automatic logic [31:0] ref_sub(input logic [31:0] w, input logic dec);
        logic [31:0] r;
        for (int l = 0; l < 4; l++)
            r[8*l +: 8] = dec ? isb[w[8*l +: 8]] : sb[w[8*l +: 8]];
        return r;
    endfunction

`ifdef SBOX_PIPE_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Model: expected results travel through a LAT-deep queue advanced on enabled edges.
    logic        m_last;
    logic        q_vld [LAT];
    logic [31:0] q_dat [LAT];
    logic        q_id  [LAT];
    logic [31:0] m_dout;
    logic        m_id;
    logic        gnt_d_last, gnt_k_last;
    logic [31:0] cap [$];

    task automatic model_reset();
        m_last = 1'b1;
        m_dout = 32'h0;
        m_id   = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            q_vld[i] = 1'b0; q_dat[i] = 32'h0; q_id[i] = 1'b0;
        end
        gnt_d_last = 1'b0;
        gnt_k_last = 1'b0;
    endtask

    task automatic cycle();
        logic exp_d, exp_k, busy_m;
        logic [31:0] nw;
        #1;
        exp_d = EN & d_vld & (~k_vld | m_last);
        exp_k = EN & k_vld & (~d_vld | ~m_last);
        check("d_rdy", d_rdy, exp_d);
        check("k_rdy", k_rdy, exp_k);
        check("one_grant", d_rdy & k_rdy, 0);
        nw = exp_d ? ref_sub(d_din, d_dec) : ref_sub(k_din, 1'b0);
        @(posedge CLK);
        if (EN) begin
            if (exp_d | exp_k) m_last = exp_k;
            if (q_vld[LAT-1]) begin
                m_dout = q_dat[LAT-1];
                m_id   = q_id[LAT-1];
            end
            for (int i = LAT-1; i > 0; i--) begin
                q_vld[i] = q_vld[i-1]; q_dat[i] = q_dat[i-1]; q_id[i] = q_id[i-1];
            end
            q_vld[0] = exp_d | exp_k;
            q_dat[0] = nw;
            q_id[0]  = exp_k;
        end
        gnt_d_last = exp_d;
        gnt_k_last = exp_k;
        @(negedge CLK);
        // Queue head that just left is what dout should show now.
        if (EN && LAT == 1 && q_vld[0]) begin
            m_dout = q_dat[0];
            m_id   = q_id[0];
        end
        busy_m = 1'b0;
        for (int i = 0; i < LAT; i++) busy_m = busy_m | q_vld[i];
        check("dout_vld", dout_vld, q_vld[LAT-1]);
        check("dout", dout, (LAT == 1) ? m_dout : (q_vld[LAT-1] ? q_dat[LAT-1] : m_dout));
        check("dout_id", dout_id, (LAT == 1) ? m_id : (q_vld[LAT-1] ? q_id[LAT-1] : m_id));
        check("busy", busy, busy_m);
        if (dout_vld) cap.push_back(dout);
    endtask

    task automatic apply_reset();
        RSTn = 1'b0;
        d_vld = 1'b0; k_vld = 1'b0;
        #1;
        check("rst_dout", dout, 32'h0);
        check("rst_vld", dout_vld, 0);
        check("rst_id", dout_id, 0);
        check("rst_busy", busy, 0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        #2 RSTn = 1'b1;
    endtask

    logic [31:0] fw [256];
    logic [31:0] orig;

    initial begin
        build_tables();
        EN = 1'b0; d_dec = 1'b0; d_din = 32'h0; k_din = 32'h0;
        apply_reset();
        EN = 1'b1;

        // Forward known-answer word.
        d_vld = 1'b1; d_dec = 1'b0; d_din = 32'h0001_53FF;
        cycle();
        d_vld = 1'b0;
        for (int i = 1; i < LAT; i++) cycle();
        check("t2_dout", dout, 32'h637C_ED16);
        check("t2_id", dout_id, 0);
        cycle();

        // Inverse known-answer word.
        d_vld = 1'b1; d_dec = 1'b1; d_din = 32'h637C_ED16;
        cycle();
        d_vld = 1'b0;
        for (int i = 1; i < LAT; i++) cycle();
        check("t3_dout", dout, 32'h0001_53FF);
        cycle();

        // Reset in the middle of traffic; nothing may emerge afterwards.
        d_vld = 1'b1; d_dec = 1'b0; d_din = 32'hA5A5_A5A5;
        k_vld = 1'b1; k_din = 32'h1234_5678;
        cycle();
        #2;
        apply_reset();
        for (int i = 0; i < 3; i++) cycle();

        // Contention: grants alternate D,K,D,K starting with D.
        d_vld = 1'b1; d_dec = 1'b0; d_din = 32'h5353_5353;
        k_vld = 1'b1; k_din = 32'h0101_0101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_gnt", {d_rdy, k_rdy}, (i % 2 == 0) ? 2'b10 : 2'b01);
            cycle();
            if (dout_vld)
                check("t4_word", dout, dout_id ? 32'h7C7C_7C7C : 32'hEDED_EDED);
        end

        // EN low freezes everything; resumes with D.
        EN = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        EN = 1'b1;
        #1;
        check("t5_resume", {d_rdy, k_rdy}, 2'b10);
        cycle();
        d_vld = 1'b0; k_vld = 1'b0;
        for (int i = 0; i < LAT + 1; i++) cycle();

        // Every byte value in every lane, forward then back.
        cap.delete();
        for (int i = 0; i < 256; i++) begin
            d_vld = 1'b1; d_dec = 1'b0;
            d_din = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
            cycle();
        end
        d_vld = 1'b0;
        for (int i = 0; i < LAT + 1; i++) cycle();
        check("fwd_count", cap.size(), 256);
        for (int i = 0; i < 256; i++) fw[i] = (i < cap.size()) ? cap[i] : 32'h0;
        cap.delete();
        for (int i = 0; i < 256; i++) begin
            d_vld = 1'b1; d_dec = 1'b1; d_din = fw[i];
            cycle();
        end
        d_vld = 1'b0;
        for (int i = 0; i < LAT + 1; i++) cycle();
        check("inv_count", cap.size(), 256);
        for (int i = 0; i < 256 && i < cap.size(); i++) begin
            orig = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
            check("roundtrip", cap[i], orig);
        end

        // Random traffic; a requester holds its word until accepted.
        for (int n = 0; n < 800; n++) begin
            if (!d_vld || gnt_d_last) begin
                d_vld = $urandom_range(0, 2) != 0;
                d_dec = $urandom_range(0, 1) == 1;
                d_din = $urandom;
            end
            if (!k_vld || gnt_k_last) begin
                k_vld = $urandom_range(0, 2) != 0;
                k_din = $urandom;
            end
            EN = $urandom_range(0, 7) != 0;
            cycle();
        end
        EN = 1'b1; d_vld = 1'b0; k_vld = 1'b0;
        for (int i = 0; i < LAT + 1; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
